// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and constants for the hazard/forwarding
//                controller of the 5-stage ARM32 core.
//                fwd_sel_t   - EXE operand mux select encoding
//                mem_state_t - SRAM wait sequencer states
//                REG_W       - register tag width
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

   localparam int REG_W = 4;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,   // operand from register file
      FWD_MEM = 2'b01,   // operand from MEM-stage ALU result
      FWD_WB  = 2'b10    // operand from WB-stage value
   } fwd_sel_t;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_unit
//  Description : Combinational forwarding select for one EXE source operand.
//                MEM-stage result has priority over WB-stage value; output
//                is forced to FWD_REG when forwarding is disabled.
//  Ports       : fwd_en              forwarding enable
//                src                 source tag of the instruction in EXE
//                dest_mem, wb_en_mem MEM-stage destination and write enable
//                dest_wb,  wb_en_wb  WB-stage destination and write enable
//                sel                 operand mux select
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_unit
   import hazard_pkg::*;
(
   input  logic             fwd_en,
   input  logic [REG_W-1:0] src,
   input  logic [REG_W-1:0] dest_mem,
   input  logic             wb_en_mem,
   input  logic [REG_W-1:0] dest_wb,
   input  logic             wb_en_wb,
   output fwd_sel_t         sel
);

   always_comb begin
      sel = FWD_REG;
      if (fwd_en) begin
         if (wb_en_mem && (dest_mem == src))
            sel = FWD_MEM;
         else if (wb_en_wb && (dest_wb == src))
            sel = FWD_WB;
      end
   end

endmodule : fwd_unit
`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_ctrl
//  Description : Hazard detection, operand forwarding and SRAM wait
//                sequencing for the 5-stage ARM32 pipeline.
//  Parameters  : MEM_TIMEOUT - max WAIT cycles before forced release (>=2)
//                CNT_W       - performance counter width (counters only)
//  Options     : HAZARD_PERF_CNT_EN - adds saturating stall_cnt (hazard
//                cycles) and memwait_cnt (freeze_pipe cycles) outputs.
//  Ports       : clk, rst (async, active-high)
//                fwd_en                       forwarding / stall-only mode
//                src1_ID, src2_ID, two_src_ID ID-stage source tags
//                src1_FWRD, src2_FWRD         EXE-stage source tags
//                dest_/WB_EN_/MEM_R_EN_ EXE, MEM, WB destination info
//                mem_req_MEM, mem_ready       SRAM handshake
//                B_EXE                        branch taken in EXE
//                sel_src1, sel_src2           EXE operand mux selects
//                freeze_IF, flush_IFID, flush_IDEXE, freeze_pipe
//                mem_timeout                  sticky WAIT timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int CNT_W       = 16
`endif
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             fwd_en,
   input  logic [REG_W-1:0] src1_ID,
   input  logic [REG_W-1:0] src2_ID,
   input  logic             two_src_ID,
   input  logic [REG_W-1:0] src1_FWRD,
   input  logic [REG_W-1:0] src2_FWRD,
   input  logic [REG_W-1:0] dest_EXE,
   input  logic             WB_EN_EXE,
   input  logic             MEM_R_EN_EXE,
   input  logic [REG_W-1:0] dest_MEM,
   input  logic             WB_EN_MEM,
   input  logic             mem_req_MEM,
   input  logic             mem_ready,
   input  logic [REG_W-1:0] dest_WB,
   input  logic             WB_EN_WB,
   input  logic             B_EXE,
   output logic [1:0]       sel_src1,
   output logic [1:0]       sel_src2,
   output logic             freeze_IF,
   output logic             flush_IFID,
   output logic             flush_IDEXE,
   output logic             freeze_pipe,
   output logic             mem_timeout
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] memwait_cnt
`endif
);

   localparam int                  c_WCNT_W    = $clog2(MEM_TIMEOUT);
   localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(MEM_TIMEOUT - 1);

   // ------------------------------------------------------------------------
   // Forwarding selects
   // ------------------------------------------------------------------------
   fwd_sel_t w_sel1;
   fwd_sel_t w_sel2;

   fwd_unit u_fwd_src1 (
      .fwd_en    (fwd_en),
      .src       (src1_FWRD),
      .dest_mem  (dest_MEM),
      .wb_en_mem (WB_EN_MEM),
      .dest_wb   (dest_WB),
      .wb_en_wb  (WB_EN_WB),
      .sel       (w_sel1)
   );

   fwd_unit u_fwd_src2 (
      .fwd_en    (fwd_en),
      .src       (src2_FWRD),
      .dest_mem  (dest_MEM),
      .wb_en_mem (WB_EN_MEM),
      .dest_wb   (dest_WB),
      .wb_en_wb  (WB_EN_WB),
      .sel       (w_sel2)
   );

   // Every output is held at 0 while rst is asserted, even though the
   // combinational paths would otherwise follow the live inputs.
   assign sel_src1 = rst ? 2'b00 : w_sel1;
   assign sel_src2 = rst ? 2'b00 : w_sel2;

   // ------------------------------------------------------------------------
   // Data hazard detection
   // ------------------------------------------------------------------------
   logic w_match_exe;
   logic w_match_mem;
   logic w_hz;

   assign w_match_exe = (dest_EXE == src1_ID) || (two_src_ID && (dest_EXE == src2_ID));
   assign w_match_mem = (dest_MEM == src1_ID) || (two_src_ID && (dest_MEM == src2_ID));

   // With forwarding only a load in EXE cannot be bypassed; without it any
   // pending write in EXE or MEM must drain first.
   assign w_hz = fwd_en ? (WB_EN_EXE && MEM_R_EN_EXE && w_match_exe)
                        : ((WB_EN_EXE && w_match_exe) || (WB_EN_MEM && w_match_mem));

   // ------------------------------------------------------------------------
   // SRAM wait sequencer
   // ------------------------------------------------------------------------
   mem_state_t          r_state;
   mem_state_t          w_state_nxt;
   logic [c_WCNT_W-1:0] r_wait_cnt;
   logic                w_timeout_exit;
   logic                r_mem_timeout;
   logic                w_freeze_pipe;

   always_comb begin
      w_state_nxt    = r_state;
      w_timeout_exit = 1'b0;
      case (r_state)
         IDLE: begin
            if (mem_req_MEM && !mem_ready)
               w_state_nxt = WAIT;
         end
         WAIT: begin
            if (mem_ready) begin
               w_state_nxt = IDLE;
            end else if (r_wait_cnt == c_WCNT_LAST) begin
               w_state_nxt    = IDLE;
               w_timeout_exit = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // Counter runs only while staying in WAIT, so it is zero on every
         // entry to WAIT and cleared on every return to IDLE.
         if ((r_state == WAIT) && (w_state_nxt == WAIT))
            r_wait_cnt <= r_wait_cnt + 1'b1;
         else
            r_wait_cnt <= '0;
         if (w_timeout_exit)
            r_mem_timeout <= 1'b1;
      end
   end

   // Decoded from the IDLE state too, so the pipe is already frozen in the
   // first cycle the SRAM fails to answer.
   assign w_freeze_pipe = !rst && (((r_state == IDLE) && mem_req_MEM && !mem_ready) ||
                                   ((r_state == WAIT) && !mem_ready));

   assign freeze_pipe = w_freeze_pipe;
   assign mem_timeout = r_mem_timeout;

   // ------------------------------------------------------------------------
   // Pipeline register controls: SRAM freeze > branch > hazard
   // ------------------------------------------------------------------------
   always_comb begin
      freeze_IF   = 1'b0;
      flush_IFID  = 1'b0;
      flush_IDEXE = 1'b0;
      if (!rst && !w_freeze_pipe) begin
         if (B_EXE) begin
            flush_IFID  = 1'b1;
            flush_IDEXE = 1'b1;
         end else if (w_hz) begin
            freeze_IF   = 1'b1;
            flush_IDEXE = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // ------------------------------------------------------------------------
   // Saturating performance counters
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_memwait_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt   <= '0;
         r_memwait_cnt <= '0;
      end else begin
         if (w_hz && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_freeze_pipe && (r_memwait_cnt != {CNT_W{1'b1}}))
            r_memwait_cnt <= r_memwait_cnt + 1'b1;
      end
   end

   assign stall_cnt   = r_stall_cnt;
   assign memwait_cnt = r_memwait_cnt;
`endif

endmodule : hazard_fwd_ctrl
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_fwd_ctrl
//  Description : Self-checking bench for hazard_fwd_ctrl. Directed steps
//                followed by random traffic, all outputs compared each
//                cycle against a behavioural reference model.
//                Honours HAZARD_PERF_CNT_EN for the counter outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_ctrl;

   localparam int c_TIMEOUT = 8;
   localparam int c_CNT_W   = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       fwd_en;
   logic [3:0] src1_ID, src2_ID, src1_FWRD, src2_FWRD;
   logic       two_src_ID;
   logic [3:0] dest_EXE, dest_MEM, dest_WB;
   logic       WB_EN_EXE, MEM_R_EN_EXE, WB_EN_MEM, WB_EN_WB;
   logic       mem_req_MEM, mem_ready, B_EXE;
   logic [1:0] sel_src1, sel_src2;
   logic       freeze_IF, flush_IFID, flush_IDEXE, freeze_pipe, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
   logic [c_CNT_W-1:0] stall_cnt, memwait_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state: is an SRAM access outstanding, how many WAIT
   // cycles it has spent so far, sticky timeout, and event tallies.
   bit m_waiting;
   int m_wait_cycles;
   bit m_to;
   int m_hz_cycles;
   int m_frz_cycles;

   always #5 clk = ~clk;

   hazard_fwd_ctrl #(
      .MEM_TIMEOUT (c_TIMEOUT)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .CNT_W       (c_CNT_W)
`endif
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .fwd_en       (fwd_en),
      .src1_ID      (src1_ID),
      .src2_ID      (src2_ID),
      .two_src_ID   (two_src_ID),
      .src1_FWRD    (src1_FWRD),
      .src2_FWRD    (src2_FWRD),
      .dest_EXE     (dest_EXE),
      .WB_EN_EXE    (WB_EN_EXE),
      .MEM_R_EN_EXE (MEM_R_EN_EXE),
      .dest_MEM     (dest_MEM),
      .WB_EN_MEM    (WB_EN_MEM),
      .mem_req_MEM  (mem_req_MEM),
      .mem_ready    (mem_ready),
      .dest_WB      (dest_WB),
      .WB_EN_WB     (WB_EN_WB),
      .B_EXE        (B_EXE),
      .sel_src1     (sel_src1),
      .sel_src2     (sel_src2),
      .freeze_IF    (freeze_IF),
      .flush_IFID   (flush_IFID),
      .flush_IDEXE  (flush_IDEXE),
      .freeze_pipe  (freeze_pipe),
      .mem_timeout  (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cnt    (stall_cnt),
      .memwait_cnt  (memwait_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference rules ----------------
   function automatic logic [1:0] ref_sel(input logic [3:0] src);
      if (!fwd_en)                          return 2'd0;
      if (WB_EN_MEM && dest_MEM == src)     return 2'd1;
      if (WB_EN_WB && dest_WB == src)       return 2'd2;
      return 2'd0;
   endfunction

   function automatic bit reads(input logic [3:0] d);
      return (d == src1_ID) || (two_src_ID && d == src2_ID);
   endfunction

   function automatic bit ref_hz();
      if (fwd_en) return WB_EN_EXE && MEM_R_EN_EXE && reads(dest_EXE);
      return (WB_EN_EXE && reads(dest_EXE)) || (WB_EN_MEM && reads(dest_MEM));
   endfunction

   function automatic bit ref_frz();
      if (m_waiting) return !mem_ready;
      return mem_req_MEM && !mem_ready;
   endfunction

   task automatic model_reset();
      m_waiting = 0; m_wait_cycles = 0; m_to = 0; m_hz_cycles = 0; m_frz_cycles = 0;
   endtask

   // Advance the model by one clock with the inputs currently applied.
   task automatic model_tick();
      if (ref_hz())  m_hz_cycles++;
      if (ref_frz()) m_frz_cycles++;
      if (!m_waiting) begin
         if (mem_req_MEM && !mem_ready) begin
            m_waiting = 1; m_wait_cycles = 1;
         end
      end else if (mem_ready) begin
         m_waiting = 0;
      end else if (m_wait_cycles == c_TIMEOUT) begin
         m_waiting = 0; m_to = 1;
      end else begin
         m_wait_cycles++;
      end
   endtask

   task automatic check_all();
      bit frz, hz;
      frz = !rst && ref_frz();
      hz  = ref_hz();
      chk("sel_src1", sel_src1, rst ? 2'd0 : ref_sel(src1_FWRD));
      chk("sel_src2", sel_src2, rst ? 2'd0 : ref_sel(src2_FWRD));
      chk("freeze_pipe", freeze_pipe, frz);
      chk("freeze_IF",   freeze_IF,   !rst && !frz && !B_EXE && hz);
      chk("flush_IFID",  flush_IFID,  !rst && !frz && B_EXE);
      chk("flush_IDEXE", flush_IDEXE, !rst && !frz && (B_EXE || hz));
      chk("mem_timeout", mem_timeout, m_to);
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_cnt",   stall_cnt,   m_hz_cycles);
      chk("memwait_cnt", memwait_cnt, m_frz_cycles);
`endif
   endtask

   // Inputs are applied just after a rising edge; outputs are compared
   // mid-cycle, then the model follows the edge.
   task automatic step();
      #2;
      check_all();
      @(posedge clk);
      if (!rst) model_tick();
      #1;
   endtask

   task automatic clr();
      fwd_en = 1; src1_ID = 4'd0; src2_ID = 4'd0; two_src_ID = 0;
      src1_FWRD = 4'd0; src2_FWRD = 4'd0;
      dest_EXE = 4'd15; dest_MEM = 4'd15; dest_WB = 4'd15;
      WB_EN_EXE = 0; MEM_R_EN_EXE = 0; WB_EN_MEM = 0; WB_EN_WB = 0;
      mem_req_MEM = 0; mem_ready = 0; B_EXE = 0;
   endtask

   initial begin
      clr();
      fwd_en = 0; dest_EXE = 4'd0; dest_MEM = 4'd0; dest_WB = 4'd0;
      rst = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      chk("rst_sel_src1", sel_src1, 2'd0);
      chk("rst_freeze_IF", freeze_IF, 1'b0);
      chk("rst_flush_IDEXE", flush_IDEXE, 1'b0);
      chk("rst_freeze_pipe", freeze_pipe, 1'b0);
      chk("rst_mem_timeout", mem_timeout, 1'b0);
      @(negedge clk);
      rst = 0;
      @(posedge clk); #1;
      clr();

      // 1: MEM has priority over WB
      WB_EN_MEM = 1; dest_MEM = 4'd3; WB_EN_WB = 1; dest_WB = 4'd3; src1_FWRD = 4'd3;
      #2 chk("t1_mem_prio", sel_src1, 2'b01);
      step();
      WB_EN_MEM = 0;
      #2 chk("t1_wb_fwd", sel_src1, 2'b10);
      step();

      // 2: load-use through src2 only when the ID instruction reads it
      clr();
      MEM_R_EN_EXE = 1; WB_EN_EXE = 1; dest_EXE = 4'd5; src1_ID = 4'd1; src2_ID = 4'd5; two_src_ID = 1;
      #2 chk("t2_freeze_IF", freeze_IF, 1'b1);
      chk("t2_flush_IDEXE", flush_IDEXE, 1'b1);
      step();
      MEM_R_EN_EXE = 0;   // load has moved on: hazard gone
      #2 chk("t2_released", freeze_IF, 1'b0);
      step();
      MEM_R_EN_EXE = 1; two_src_ID = 0;
      #2 chk("t2_one_src", freeze_IF, 1'b0);
      step();

      // 3: stall-only mode
      clr();
      fwd_en = 0; WB_EN_MEM = 1; dest_MEM = 4'd2; src1_ID = 4'd2; src1_FWRD = 4'd2;
      #2 chk("t3_freeze_IF", freeze_IF, 1'b1);
      chk("t3_no_fwd", sel_src1, 2'b00);
      step();

      // 4: branch overrides load-use
      clr();
      MEM_R_EN_EXE = 1; WB_EN_EXE = 1; dest_EXE = 4'd7; src1_ID = 4'd7; B_EXE = 1;
      #2 chk("t4_flush_IFID", flush_IFID, 1'b1);
      chk("t4_flush_IDEXE", flush_IDEXE, 1'b1);
      chk("t4_freeze_IF", freeze_IF, 1'b0);
      step();

      // 5a: four-cycle SRAM wait, branch masked while frozen
      clr();
      mem_req_MEM = 1; B_EXE = 1;
      for (int i = 0; i < 4; i++) begin
         #2 chk("t5_frozen", freeze_pipe, 1'b1);
         chk("t5_branch_masked", flush_IFID, 1'b0);
         step();
      end
      mem_ready = 1;
      #2 chk("t5_release", freeze_pipe, 1'b0);
      chk("t5_branch_resumes", flush_IFID, 1'b1);
      step();
      clr(); step();

      // 5b: timeout with mem_ready held low
      mem_req_MEM = 1;
      for (int i = 0; i < c_TIMEOUT + 1; i++) step();
      mem_req_MEM = 0;
      #2 chk("t5_timeout_flag", mem_timeout, 1'b1);
      chk("t5_timeout_release", freeze_pipe, 1'b0);
      step();
      step();

      // 6: async reset in WAIT at wait count 3
      mem_req_MEM = 1;
      for (int i = 0; i < 4; i++) step();
      #2 rst = 1;
      #1 chk("t6_freeze_pipe", freeze_pipe, 1'b0);
      chk("t6_mem_timeout", mem_timeout, 1'b0);
      chk("t6_flush_IDEXE", flush_IDEXE, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
      chk("t6_stall_cnt", stall_cnt, 0);
      chk("t6_memwait_cnt", memwait_cnt, 0);
`endif
      model_reset();
      @(negedge clk);
      rst = 0;
      mem_req_MEM = 0;
      @(posedge clk); #1;

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         fwd_en       = ($urandom_range(0, 3) != 0);
         src1_ID      = 4'($urandom_range(0, 3));
         src2_ID      = 4'($urandom_range(0, 3));
         two_src_ID   = 1'($urandom);
         src1_FWRD    = 4'($urandom_range(0, 3));
         src2_FWRD    = 4'($urandom_range(0, 3));
         dest_EXE     = 4'($urandom_range(0, 3));
         dest_MEM     = 4'($urandom_range(0, 3));
         dest_WB      = 4'($urandom_range(0, 3));
         WB_EN_EXE    = 1'($urandom);
         MEM_R_EN_EXE = 1'($urandom);
         WB_EN_MEM    = 1'($urandom);
         WB_EN_WB     = 1'($urandom);
         B_EXE        = ($urandom_range(0, 6) == 0);
         mem_req_MEM  = ($urandom_range(0, 2) == 0);
         mem_ready    = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_hazard_fwd_ctrl
`default_nettype wire
